mna_flit_depacketizer: RTL



---
 rtl/mna_pkg.sv | 9 +
 rtl/mna_sync_fifo.sv | 34 +++
 rtl/mna_flit_depacketizer.sv | 96 +++++++++
 3 files changed

// File: rtl/mna_pkg.sv
// mna_pkg: flit type codes, depacketizer state encoding and flit field widths.
package mna_pkg;
  localparam logic [1:0] FLIT_BODY = 2'b00;
  localparam logic [1:0] FLIT_TAIL = 2'b01;
  localparam logic [1:0] FLIT_HEAD = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;
  localparam int FLIT_TYPE_W = 2;
  typedef enum logic {ST_IDLE = 1'b0, ST_PKT = 1'b1} state_t;
endpackage

// File: rtl/mna_sync_fifo.sv
// mna_sync_fifo: synchronous FIFO with wrap-bit pointers; no push when full.
module mna_sync_fifo #(
  parameter int W = 36,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [W-1:0] mem [DEPTH];
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign rd_data = mem[rp[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en && !full) begin
        mem[wp[AW-1:0]] <= wr_data;
        wp <= wp + (AW+1)'(1);
      end
      if (rd_en && !empty) rp <= rp + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/mna_flit_depacketizer.sv
// mna_flit_depacketizer: NoC flit framing FSM, head capture and payload FIFO.
// Optional MNA_DEPKT_ERR_CNT_EN adds a saturating 8-bit framing error counter.
module mna_flit_depacketizer
  import mna_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W = 3,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FLIT_TYPE_W+DATA_W+TAG_W-1:0] noc_flit,
  input  logic                          noc_valid,
  output logic                          noc_ready,
  output logic [DATA_W-1:0]             hdr_data,
  output logic [TAG_W-1:0]              hdr_tag,
  output logic                          hdr_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic [TAG_W-1:0]              out_tag,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
`ifdef MNA_DEPKT_ERR_CNT_EN
  output logic                          err,
  output logic [7:0]                    err_cnt
`else
  output logic                          err
`endif
);
  localparam int FW = 1 + DATA_W + TAG_W;
  state_t state, state_n;
  logic [1:0] ftype;
  logic full, empty, accept, push, push_last, hdr_cap, err_n;
  logic [FW-1:0] rd_word;
  assign ftype = noc_flit[FLIT_TYPE_W+DATA_W+TAG_W-1 -: FLIT_TYPE_W];
  assign noc_ready = !full;
  assign accept = noc_valid && noc_ready;
  assign out_valid = !empty;
  assign busy = state == ST_PKT;
  assign {out_last, out_data, out_tag} = rd_word;
  always_comb begin
    state_n = state;
    push = 1'b0;
    push_last = 1'b0;
    hdr_cap = 1'b0;
    err_n = 1'b0;
    if (accept) begin
      if (state == ST_IDLE) begin
        hdr_cap = ftype == FLIT_HEAD;
        push = ftype == FLIT_SINGLE;
        push_last = 1'b1;
        err_n = ftype == FLIT_BODY || ftype == FLIT_TAIL;
        state_n = ftype == FLIT_HEAD ? ST_PKT : ST_IDLE;
      end else begin
        push = ftype == FLIT_BODY || ftype == FLIT_TAIL;
        push_last = ftype == FLIT_TAIL;
        err_n = ftype == FLIT_HEAD || ftype == FLIT_SINGLE;
        state_n = ftype == FLIT_TAIL ? ST_IDLE : ST_PKT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      hdr_data <= '0;
      hdr_tag <= '0;
      hdr_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      hdr_valid <= hdr_cap;
      err <= err_n;
      if (hdr_cap) begin
        hdr_data <= noc_flit[TAG_W+DATA_W-1:TAG_W];
        hdr_tag <= noc_flit[TAG_W-1:0];
      end
    end
  end
`ifdef MNA_DEPKT_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else if (err_n && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
  end
`endif
  mna_sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .wr_data({push_last, noc_flit[DATA_W+TAG_W-1:0]}),
    .rd_en(out_ready),
    .rd_data(rd_word),
    .full(full),
    .empty(empty)
  );
endmodule
